// File: rtl/mm_result_collector.sv
// mm_result_collector: captures a burst of packed 5x int8 result rows from the
// matrix-multiply array into a row buffer. Each row has optional per-lane ReLU
// and an overflow tag. When the burst ends, the frame is replayed in order over
// a ready/valid stream, with a last marker on the final row. The block also
// keeps sticky overflow and protocol-error status.
//
// Ports:
//   clk, reset_n            clock, async active-low reset
//   res_i/val_i/ov_i        incoming result row, valid strobe, overflow tag
//   relu_en                 clamp negative lanes to zero on capture
//   clr_i                   clears ovf_sticky_o and err_o
//   m_data_o/m_ovf_o        replayed row and its stored overflow tag
//   m_valid_o/m_ready_i     stream handshake
//   m_last_o                final row of the frame
//   busy_o                  capture or drain in progress
//   rows_o                  row count of the current or last frame
//   ovf_sticky_o, err_o     sticky status
module mm_result_collector #(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned AW    = 5
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [39:0]     res_i,
  input  logic            val_i,
  input  logic            ov_i,
  input  logic            relu_en,
  input  logic            clr_i,
  output logic [39:0]     m_data_o,
  output logic            m_ovf_o,
  output logic            m_valid_o,
  input  logic            m_ready_i,
  output logic            m_last_o,
  output logic            busy_o,
  output logic [AW:0]     rows_o,
  output logic            ovf_sticky_o,
  output logic            err_o
);

  localparam int unsigned DW    = 40;
  localparam int unsigned LANES = 5;
  localparam int unsigned RW    = DW + 1;

  typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} state_t;

  state_t          state;
  logic [AW-1:0]   rd_ptr;
  logic [RW-1:0]   mem [DEPTH];

  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic            drop;
  logic [AW-1:0]   rd_addr;
  logic [RW-1:0]   rd_row;

  // Zero every lane whose sign bit is set when ReLU is enabled.
  function automatic logic [DW-1:0] relu_row(input logic [DW-1:0] r, input logic en);
    logic [DW-1:0] o;
    o = r;
    for (int i = 0; i < LANES; i++) begin
      if (en && r[8*i+7]) o[8*i +: 8] = 8'h00;
    end
    return o;
  endfunction

  // Write/drop decode for the incoming row.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = '0;
    drop    = 1'b0;
    case (state)
      IDLE: begin
        wr_en = val_i;
      end
      CAPTURE: begin
        if (rows_o < (AW+1)'(DEPTH)) begin
          wr_en   = val_i;
          wr_addr = rows_o[AW-1:0];
        end else begin
          drop = val_i;
        end
      end
      DRAIN: begin
        drop = val_i;
      end
      default: begin
        wr_en = 1'b0;
      end
    endcase
  end

  // The first load of a drain reads entry 0; later loads read the next entry.
  assign rd_addr = m_valid_o ? (rd_ptr + AW'(1)) : AW'(0);
  assign rd_row  = mem[rd_addr];

  // Row buffer: contents need no reset, and a frame is only read after it has been written.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= {relu_row(res_i, relu_en), ov_i};
  end

  // Control FSM with registered stream and status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      rd_ptr       <= '0;
      rows_o       <= '0;
      m_data_o     <= '0;
      m_ovf_o      <= 1'b0;
      m_valid_o    <= 1'b0;
      m_last_o     <= 1'b0;
      busy_o       <= 1'b0;
      ovf_sticky_o <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      // A set in the same cycle takes priority over clr_i.
      ovf_sticky_o <= (wr_en & ov_i) | (ovf_sticky_o & ~clr_i);
      err_o        <= drop | (err_o & ~clr_i);
      case (state)
        IDLE: begin
          if (val_i) begin
            rows_o <= (AW+1)'(1);
            state  <= CAPTURE;
            busy_o <= 1'b1;
          end
        end
        CAPTURE: begin
          if (!val_i) begin
            rd_ptr <= '0;
            state  <= DRAIN;
          end else if (wr_en) begin
            rows_o <= rows_o + (AW+1)'(1);
          end
        end
        DRAIN: begin
          if (!m_valid_o) begin
            m_data_o  <= rd_row[RW-1:1];
            m_ovf_o   <= rd_row[0];
            m_valid_o <= 1'b1;
            m_last_o  <= (rows_o == (AW+1)'(1));
          end else if (m_ready_i) begin
            if (m_last_o) begin
              m_valid_o <= 1'b0;
              m_last_o  <= 1'b0;
              state     <= IDLE;
              busy_o    <= 1'b0;
            end else begin
              m_data_o <= rd_row[RW-1:1];
              m_ovf_o  <= rd_row[0];
              rd_ptr   <= rd_ptr + AW'(1);
              m_last_o <= ((AW+1)'(rd_ptr) + (AW+1)'(2) == rows_o);
            end
          end
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
